// File: rtl/gate_sequencer.sv
// Gate sequencer: walks gate ids through the netlist ROM, fetches operand labels, issues gates in
// order to the garbling engine and writes results back. Define FREE_XOR_EN for local XOR evaluation.
module gate_sequencer #(
  parameter int S = 20,
  parameter int K = 128,
  parameter int D = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [S-1:0] i_num_gates,
  output logic         o_busy,
  output logic         o_done,
  output logic [S-1:0] o_gid,
  input  logic [S-1:0] i_input_size,
  input  logic         i_in0f,
  input  logic         i_in1f,
  input  logic [S-1:0] i_in0,
  input  logic [S-1:0] i_in1,
  input  logic [3:0]   i_g_logic,
  output logic [S-1:0] o_il_addr0,
  output logic [S-1:0] o_il_addr1,
  input  logic [K-1:0] i_il_data0,
  input  logic [K-1:0] i_il_data1,
  output logic [S-1:0] o_wl_raddr0,
  output logic [S-1:0] o_wl_raddr1,
  input  logic [K-1:0] i_wl_rdata0,
  input  logic [K-1:0] i_wl_rdata1,
  output logic         o_wl_we,
  output logic [S-1:0] o_wl_waddr,
  output logic [K-1:0] o_wl_wdata,
  output logic         o_iss_valid,
  input  logic         i_iss_ready,
  output logic [K-1:0] o_iss_a,
  output logic [K-1:0] o_iss_b,
  output logic [3:0]   o_iss_logic,
  output logic [S-1:0] o_iss_gid,
  input  logic         i_res_valid,
  input  logic [K-1:0] i_res_label
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | gid on ROM, stall on hazard / full in-flight FIFO, else launch operand reads
  // WAIT   | operand read data arrives, captured into issue registers
  // ISSUE  | offering gate to engine until accepted
  // XWR    | free-XOR write deferred behind an engine writeback
  // DRAIN  | all gates issued, waiting for outstanding results
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_XWR, S_DRAIN, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [S-1:0]  r_gid, r_num;
  logic [K-1:0]  r_iss_a, r_iss_b;
  logic [3:0]    r_iss_logic;
  logic [S-1:0]  r_fifo [D];
  logic [D-1:0]  r_fvld;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic [S-1:0]  w_ra0, w_ra1;
  logic          w_haz, w_full, w_pop, w_push, w_start, w_fetch, w_cap, w_adv, w_last;
  logic          w_xor_we;
  logic [K-1:0]  w_op_a, w_op_b, w_xor_data;

  assign w_ra0  = i_in0 - i_input_size;
  assign w_ra1  = i_in1 - i_input_size;
  assign w_full = (r_count == CW'(D));
  assign w_pop  = i_res_valid && (r_count != '0);
  assign w_last = (r_gid == r_num - S'(1));
  assign w_op_a = i_in0f ? i_il_data0 : i_wl_rdata0;
  assign w_op_b = i_in1f ? i_il_data1 : i_wl_rdata1;

  // An entry stays visible through its pop cycle so the dependent read lands after the RAM write.
  always_comb begin
    w_haz = w_full;
    for (int i = 0; i < D; i++) begin
      if (r_fvld[i] && ((!i_in0f && r_fifo[i] == w_ra0) || (!i_in1f && r_fifo[i] == w_ra1)))
        w_haz = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_fetch    = 1'b0;
    w_cap      = 1'b0;
    w_push     = 1'b0;
    w_adv      = 1'b0;
    w_xor_we   = 1'b0;
    w_xor_data = '0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start = 1'b1;
          w_next  = (i_num_gates == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (!w_haz) begin
          w_fetch = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cap  = 1'b1;
        w_next = S_ISSUE;
`ifdef FREE_XOR_EN
        if (i_g_logic == 4'b0110) begin
          if (w_pop) begin
            w_next = S_XWR;
          end else begin
            w_xor_we   = 1'b1;
            w_xor_data = w_op_a ^ w_op_b;
            w_adv      = 1'b1;
            w_next     = w_last ? S_DRAIN : S_FETCH;
          end
        end
`endif
      end
      S_ISSUE: begin
        if (i_iss_ready) begin
          w_push = 1'b1;
          w_adv  = 1'b1;
          w_next = w_last ? S_DRAIN : S_FETCH;
        end
      end
`ifdef FREE_XOR_EN
      S_XWR: begin
        if (!w_pop) begin
          w_xor_we   = 1'b1;
          w_xor_data = r_iss_a ^ r_iss_b;
          w_adv      = 1'b1;
          w_next     = w_last ? S_DRAIN : S_FETCH;
        end
      end
`endif
      S_DRAIN: begin
        if (r_count == '0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gid       <= '0;
      r_num       <= '0;
      r_iss_a     <= '0;
      r_iss_b     <= '0;
      r_iss_logic <= '0;
    end else begin
      if (w_start) begin
        r_gid <= '0;
        r_num <= i_num_gates;
      end else if (w_adv) begin
        r_gid <= r_gid + S'(1);
      end
      if (w_cap) begin
        r_iss_a     <= w_op_a;
        r_iss_b     <= w_op_b;
        r_iss_logic <= i_g_logic;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fvld  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < D; i++) r_fifo[i] <= '0;
    end else begin
      if (w_pop) begin
        r_fvld[r_rptr] <= 1'b0;
        r_rptr         <= (r_rptr == PW'(D - 1)) ? '0 : r_rptr + PW'(1);
      end
      if (w_push) begin
        r_fifo[r_wptr] <= r_gid;
        r_fvld[r_wptr] <= 1'b1;
        r_wptr         <= (r_wptr == PW'(D - 1)) ? '0 : r_wptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_gid       = r_gid;
  assign o_il_addr0  = (w_fetch && i_in0f)  ? i_in0 : '0;
  assign o_il_addr1  = (w_fetch && i_in1f)  ? i_in1 : '0;
  assign o_wl_raddr0 = (w_fetch && !i_in0f) ? w_ra0 : '0;
  assign o_wl_raddr1 = (w_fetch && !i_in1f) ? w_ra1 : '0;
  assign o_iss_valid = (r_state == S_ISSUE);
  assign o_iss_a     = r_iss_a;
  assign o_iss_b     = r_iss_b;
  assign o_iss_logic = r_iss_logic;
  assign o_iss_gid   = r_gid;
  // Engine writeback wins the RAM port; a colliding local XOR write waits in XWR.
  assign o_wl_we     = w_pop || w_xor_we;
  assign o_wl_waddr  = w_pop ? r_fifo[r_rptr] : (w_xor_we ? r_gid : '0);
  assign o_wl_wdata  = w_pop ? i_res_label : w_xor_data;

endmodule

// File: tb/tb_gate_sequencer.sv
// Bench for gate_sequencer: ROM/label memories and an in-order engine model around the DUT;
// expected writebacks go into a scoreboard queue at issue and are compared on wl_we.
module tb_gate_sequencer;
  localparam int S = 20, K = 128, D = 4;
  localparam logic [K-1:0] POISON = {4{32'hDEAD_BEEF}};

  logic         i_clk = 1'b0;
  logic         i_rst, i_start;
  logic [S-1:0] i_num_gates, i_input_size, i_in0, i_in1;
  logic         i_in0f, i_in1f;
  logic [3:0]   i_g_logic;
  logic         o_busy, o_done, o_wl_we, o_iss_valid, i_iss_ready, i_res_valid;
  logic [S-1:0] o_gid, o_il_addr0, o_il_addr1, o_wl_raddr0, o_wl_raddr1, o_wl_waddr, o_iss_gid;
  logic [K-1:0] i_il_data0, i_il_data1, i_wl_rdata0, i_wl_rdata1, o_wl_wdata;
  logic [K-1:0] o_iss_a, o_iss_b, i_res_label;
  logic [3:0]   o_iss_logic;

  gate_sequencer #(.S(S), .K(K), .D(D)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_gates(i_num_gates),
    .o_busy(o_busy), .o_done(o_done), .o_gid(o_gid), .i_input_size(i_input_size),
    .i_in0f(i_in0f), .i_in1f(i_in1f), .i_in0(i_in0), .i_in1(i_in1), .i_g_logic(i_g_logic),
    .o_il_addr0(o_il_addr0), .o_il_addr1(o_il_addr1), .i_il_data0(i_il_data0),
    .i_il_data1(i_il_data1), .o_wl_raddr0(o_wl_raddr0), .o_wl_raddr1(o_wl_raddr1),
    .i_wl_rdata0(i_wl_rdata0), .i_wl_rdata1(i_wl_rdata1), .o_wl_we(o_wl_we),
    .o_wl_waddr(o_wl_waddr), .o_wl_wdata(o_wl_wdata), .o_iss_valid(o_iss_valid),
    .i_iss_ready(i_iss_ready), .o_iss_a(o_iss_a), .o_iss_b(o_iss_b), .o_iss_logic(o_iss_logic),
    .o_iss_gid(o_iss_gid), .i_res_valid(i_res_valid), .i_res_label(i_res_label)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [S-1:0] addr; logic [K-1:0] data; } wr_t;
  typedef struct { logic [K-1:0] lab; int due; } eng_t;
  wr_t  sb[$];
  eng_t eq[$];
  eng_t e;
  wr_t  w;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, lat = 2, exp_gid = 0, n_issued = 0, n_done = 0, n_wr = 0, isz = 16;
  logic ready_en = 1'b1, withhold = 1'b0, ram_clear = 1'b0;
  int rom_in0 [64], rom_in1 [64], first_iss [64], wb_cyc [64];
  logic [3:0]   rom_logic [64];
  logic [K-1:0] ga [64], gb [64], gout [64], wl_ram [64];
  int rom_idx;

  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [K-1:0] il_lab(input int wi);
    logic [31:0] v;
    v = wi;
    return {32'h1000_0000 + v, 32'hC0DE_0000 ^ v, ~v, 32'h5A5A_5A5A + (v << 3)};
  endfunction

  function automatic logic [K-1:0] eng_f(input logic [K-1:0] a, input logic [K-1:0] b,
                                         input logic [3:0] l);
    return {a[K-2:0], a[K-1]} ^ b ^ {32{l}};
  endfunction

  function automatic logic [K-1:0] lab(input int wi);
    return (wi < isz) ? il_lab(wi) : gout[(wi - isz) & 63];
  endfunction

  // Netlist ROM (combinational on gid)
  assign rom_idx = int'(o_gid) & 63;
  always_comb begin
    i_in0        = S'(rom_in0[rom_idx]);
    i_in1        = S'(rom_in1[rom_idx]);
    i_in0f       = rom_in0[rom_idx] < isz;
    i_in1f       = rom_in1[rom_idx] < isz;
    i_g_logic    = rom_logic[rom_idx];
    i_input_size = S'(isz);
  end

  // Label memories, one-cycle read latency
  always @(posedge i_clk) begin
    i_il_data0 <= il_lab(int'(o_il_addr0));
    i_il_data1 <= il_lab(int'(o_il_addr1));
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) wl_ram[i] <= POISON;
    end else if (o_wl_we) begin
      wl_ram[int'(o_wl_waddr) & 63] <= o_wl_wdata;
    end
    i_wl_rdata0 <= wl_ram[int'(o_wl_raddr0) & 63];
    i_wl_rdata1 <= wl_ram[int'(o_wl_raddr1) & 63];
  end

  // Engine model + monitor: drive at negedge, observe the committing cycle 1 unit later
  always @(negedge i_clk) begin
    i_iss_ready = ready_en;
    if (!i_rst && !withhold && eq.size() > 0 && eq[0].due <= cyc) begin
      e = eq.pop_front();
      i_res_valid = 1'b1;
      i_res_label = e.lab;
    end else begin
      i_res_valid = 1'b0;
      i_res_label = '0;
    end
    #1;
    if (i_rst) begin
      eq.delete();
      sb.delete();
    end else begin
      if (o_iss_valid && first_iss[int'(o_iss_gid) & 63] < 0) first_iss[int'(o_iss_gid) & 63] = cyc;
      if (o_iss_valid && i_iss_ready) begin
        chk("iss_gid", K'(o_iss_gid), K'(exp_gid));
        chk("iss_a", o_iss_a, ga[exp_gid & 63]);
        chk("iss_b", o_iss_b, gb[exp_gid & 63]);
        chk("iss_logic", K'(o_iss_logic), K'(rom_logic[exp_gid & 63]));
        eq.push_back('{lab: eng_f(o_iss_a, o_iss_b, o_iss_logic), due: cyc + lat});
        sb.push_back('{addr: S'(exp_gid), data: gout[exp_gid & 63]});
        exp_gid++;
        n_issued++;
      end
      if (o_wl_we) begin
        n_wr++;
        if (sb.size() == 0) begin
          chk("wr_unexpected", K'(o_wl_waddr), POISON);
        end else begin
          w = sb.pop_front();
          chk("wr_addr", K'(o_wl_waddr), K'(w.addr));
          chk("wr_data", o_wl_wdata, w.data);
          wb_cyc[int'(o_wl_waddr) & 63] = cyc;
        end
      end
      if (o_done) n_done++;
    end
    cyc++;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_gate(input int g, input int a, input int b, input logic [3:0] l);
    rom_in0[g] = a;
    rom_in1[g] = b;
    rom_logic[g] = l;
  endtask

  task automatic clear_bench();
    n_issued = 0; n_done = 0; n_wr = 0;
    for (int i = 0; i < 64; i++) begin
      first_iss[i] = -1;
      wb_cyc[i] = -1;
    end
    ram_clear = 1'b1;
    step();
    ram_clear = 1'b0;
  endtask

  task automatic start_run(input int n);
    for (int g = 0; g < n; g++) begin
      ga[g]   = lab(rom_in0[g]);
      gb[g]   = lab(rom_in1[g]);
      gout[g] = eng_f(ga[g], gb[g], rom_logic[g]);
    end
    exp_gid = 0;
    i_num_gates = S'(n);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      step();
      k++;
    end
    if (n_done == 0) chk({tag, "_timeout"}, K'(0), K'(1));
  endtask

  task automatic end_checks(input string tag, input int n);
    step();
    chk({tag, "_busy"}, K'(o_busy), K'(0));
    chk({tag, "_done_cnt"}, K'(n_done), K'(1));
    chk({tag, "_issues"}, K'(n_issued), K'(n));
    chk({tag, "_writes"}, K'(n_wr), K'(n));
    chk({tag, "_sb_empty"}, K'(sb.size()), K'(0));
  endtask

  task automatic netlist_t1();
    set_gate(0, 0, 1, 4'b1000);
    set_gate(1, 2, 3, 4'b1000);
    set_gate(2, 4, 5, 4'b1000);
  endtask

  initial begin
    int n_unst, k;
    logic [K-1:0] sa, sbv;
    logic [3:0]   sl;
    logic [S-1:0] sg;
    i_rst = 1'b1; i_start = 1'b0; i_num_gates = '0;
    for (int i = 0; i < 64; i++) begin
      rom_in0[i] = 0; rom_in1[i] = 0; rom_logic[i] = 4'b0;
      first_iss[i] = -1; wb_cyc[i] = -1;
    end
    repeat (3) step();
    chk("rst_busy", K'(o_busy), K'(0));
    chk("rst_done", K'(o_done), K'(0));
    chk("rst_gid", K'(o_gid), K'(0));
    chk("rst_iss_valid", K'(o_iss_valid), K'(0));
    chk("rst_wl_we", K'(o_wl_we), K'(0));
    #1 i_rst = 1'b0;

    // T1: independent AND gates on inputs only
    netlist_t1();
    lat = 2;
    clear_bench();
    start_run(3);
    wait_done("t1", 300);
    end_checks("t1", 3);

    // T2: dependency chain, long engine latency
    set_gate(0, 0, 1, 4'b1000);
    set_gate(1, 16, 2, 4'b1110);
    set_gate(2, 17, 16, 4'b0001);
    set_gate(3, 5, 18, 4'b1001);
    lat = 10;
    clear_bench();
    start_run(4);
    wait_done("t2", 500);
    end_checks("t2", 4);
    chk("t2_order_g1", K'(first_iss[1] > wb_cyc[0] && wb_cyc[0] >= 0), K'(1));
    chk("t2_order_g2", K'(first_iss[2] > wb_cyc[1] && wb_cyc[1] >= 0), K'(1));
    chk("t2_order_g3", K'(first_iss[3] > wb_cyc[2] && wb_cyc[2] >= 0), K'(1));

    // T3: issue held off by iss_ready low
    netlist_t1();
    lat = 2;
    ready_en = 1'b0;
    clear_bench();
    start_run(2);
    k = 0;
    while (!o_iss_valid && k < 20) begin
      step();
      k++;
    end
    chk("t3_valid_seen", K'(o_iss_valid), K'(1));
    sa = o_iss_a; sbv = o_iss_b; sl = o_iss_logic; sg = o_iss_gid;
    n_unst = 0;
    repeat (20) begin
      step();
      if (!o_iss_valid || o_iss_a !== sa || o_iss_b !== sbv || o_iss_logic !== sl ||
          o_iss_gid !== sg) n_unst++;
    end
    chk("t3_stable", K'(n_unst), K'(0));
    chk("t3_no_push", K'(n_issued), K'(0));
    ready_en = 1'b1;
    wait_done("t3", 300);
    end_checks("t3", 2);

    // T4: in-flight limit with results withheld
    for (int g = 0; g < 8; g++) set_gate(g, g, g + 8, 4'b1000 ^ 4'(g));
    lat = 1;
    withhold = 1'b1;
    clear_bench();
    start_run(8);
    repeat (60) step();
    chk("t4_cap_issues", K'(n_issued), K'(D));
    chk("t4_no_writes", K'(n_wr), K'(0));
    chk("t4_busy", K'(o_busy), K'(1));
    withhold = 1'b0;
    wait_done("t4", 500);
    end_checks("t4", 8);

    // T5: zero gates, then start while busy
    clear_bench();
    start_run(0);
    wait_done("t5", 20);
    end_checks("t5", 0);
    lat = 2;
    clear_bench();
    start_run(3);
    repeat (3) step();
    i_num_gates = S'(5);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    wait_done("t5b", 300);
    end_checks("t5b", 3);

    // T6: async reset mid-run, then a fresh run from gid 0
    lat = 5;
    clear_bench();
    start_run(8);
    repeat (12) step();
    #2 i_rst = 1'b1;
    #1;
    chk("t6_busy", K'(o_busy), K'(0));
    chk("t6_iss_valid", K'(o_iss_valid), K'(0));
    chk("t6_gid", K'(o_gid), K'(0));
    chk("t6_wl_we", K'(o_wl_we), K'(0));
    chk("t6_iss_a", o_iss_a, K'(0));
    chk("t6_done", K'(o_done), K'(0));
    repeat (2) step();
    i_rst = 1'b0;
    netlist_t1();
    lat = 2;
    clear_bench();
    start_run(3);
    wait_done("t6", 300);
    end_checks("t6", 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
